// File: rtl/layer_demapping_pkg.sv
// Shared layer-map definitions for the receive-side layer demapper.
// The transmit-side layer mapper uses the same constants and index
// functions, so both ends place symbols identically.
package layer_demapping_pkg;

  localparam int SYM_W         = 32;
  localparam int LAYERS_PER_CW = 4;
  localparam int NUM_CW        = 2;
  localparam int SYM_PER_LAYER = 2;

  localparam int NL      = NUM_CW * LAYERS_PER_CW;
  localparam int CW_SYMS = LAYERS_PER_CW * SYM_PER_LAYER;
  localparam int CW_W    = SYM_W * CW_SYMS;
  localparam int BEAT_W  = NL * SYM_W;
  localparam int CNT_W   = $clog2(SYM_PER_LAYER);

  // Position of layer 'layer' symbol-time 'beat' inside its codeword.
  function automatic int sym_index(input int layer, input int beat);
    return (layer % LAYERS_PER_CW) + beat * LAYERS_PER_CW;
  endfunction

  // Which codeword a layer belongs to.
  function automatic int cw_index(input int layer);
    return layer / LAYERS_PER_CW;
  endfunction

endpackage

// File: rtl/layer_demapping.sv
// Receive-side layer demapper: gathers SYM_PER_LAYER beats of per-layer
// symbols and rebuilds both codewords, offered together on a valid/ready
// output port.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// a block transfers on a rising edge where out_valid && out_ready. Valid
// holders keep data stable until the transfer. Only the final beat of a
// block can be stalled, and only while an unconsumed block is held.
module layer_demapping
  import layer_demapping_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic [0:BEAT_W-1] layer_sym,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:CW_W-1]   codeword0,
  output logic [0:CW_W-1]   codeword1,
  output logic              err_resync
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SYM_PER_LAYER - 1);

  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] eff_beat;
  logic             accept;
  logic             resync;
  logic             final_beat;

  // Earlier beats of the current block, one symbol per layer per beat.
  logic [SYM_W-1:0] acc_buf [0:SYM_PER_LAYER-2][0:NL-1];

  // Beat acceptance, resync detection and final-beat decode.
  always_comb begin
    in_ready   = !((beat_cnt == LAST_BEAT) && out_valid && !out_ready);
    accept     = in_valid && in_ready;
    // in_first mid-block restarts the block with this beat as beat 0.
    resync     = accept && in_first && (beat_cnt != '0);
    eff_beat   = resync ? '0 : beat_cnt;
    final_beat = accept && (eff_beat == LAST_BEAT);
  end

  // Beat counter: advances per accepted beat, wraps on the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= final_beat ? '0 : eff_beat + 1'b1;
    end
  end

  // Accumulation buffer: non-final beats are parked here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < SYM_PER_LAYER - 1; b++) begin
        for (int l = 0; l < NL; l++) begin
          acc_buf[b][l] <= '0;
        end
      end
    end else if (accept && !final_beat) begin
      for (int b = 0; b < SYM_PER_LAYER - 1; b++) begin
        if (eff_beat == CNT_W'(b)) begin
          for (int l = 0; l < NL; l++) begin
            acc_buf[b][l] <= layer_sym[l*SYM_W +: SYM_W];
          end
        end
      end
    end
  end

  // Output register: buffer plus final beat load both codewords at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codeword0 <= '0;
      codeword1 <= '0;
      out_valid <= 1'b0;
    end else begin
      if (final_beat) begin
        for (int b = 0; b < SYM_PER_LAYER - 1; b++) begin
          for (int l = 0; l < NL; l++) begin
            if (cw_index(l) == 0) begin
              codeword0[sym_index(l, b)*SYM_W +: SYM_W] <= acc_buf[b][l];
            end else begin
              codeword1[sym_index(l, b)*SYM_W +: SYM_W] <= acc_buf[b][l];
            end
          end
        end
        for (int l = 0; l < NL; l++) begin
          if (cw_index(l) == 0) begin
            codeword0[sym_index(l, SYM_PER_LAYER-1)*SYM_W +: SYM_W] <= layer_sym[l*SYM_W +: SYM_W];
          end else begin
            codeword1[sym_index(l, SYM_PER_LAYER-1)*SYM_W +: SYM_W] <= layer_sym[l*SYM_W +: SYM_W];
          end
        end
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // One-cycle flag whenever a partial block is thrown away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_resync <= 1'b0;
    end else begin
      err_resync <= resync;
    end
  end

endmodule

// File: tb/tb_layer_demapping.sv
// Testbench for layer_demapping: literal vector table, directed corner
// sequences, and a randomized round trip through a transmit-side model.
module tb_layer_demapping;
  import layer_demapping_pkg::*;

  localparam int CHUNK = CW_W / SYM_PER_LAYER;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_first;
  logic [0:BEAT_W-1] layer_sym;
  logic              out_valid;
  logic              out_ready;
  logic [0:CW_W-1]   codeword0;
  logic [0:CW_W-1]   codeword1;
  logic              err_resync;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [2*CW_W-1:0] exp_q[$];

  typedef struct {
    logic [0:BEAT_W-1] b0;
    logic [0:BEAT_W-1] b1;
    logic [0:CW_W-1]   e0;
    logic [0:CW_W-1]   e1;
  } vec_t;
  vec_t vecs[3];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  layer_demapping dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_first   (in_first),
    .layer_sym  (layer_sym),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .codeword0  (codeword0),
    .codeword1  (codeword1),
    .err_resync (err_resync)
  );

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [CW_W-1:0] act, input logic [CW_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [0:BEAT_W-1] d);
    in_valid  = v;
    in_first  = f;
    layer_sym = d;
  endtask

  task automatic rand_cw(output logic [0:CW_W-1] c);
    for (int i = 0; i < CW_SYMS; i++) c[i*SYM_W +: SYM_W] = $urandom();
  endtask

  // Transmit-side model: symbol-time b carries chunk b of each codeword,
  // codeword 0 on the lower-numbered layers.
  function automatic logic [0:BEAT_W-1] map_beat(input logic [0:CW_W-1] c0,
                                                 input logic [0:CW_W-1] c1,
                                                 input int b);
    return {c0[b*CHUNK +: CHUNK], c1[b*CHUNK +: CHUNK]};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk1("rt_no_resync", err_resync, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rt_unexpected: got a block, want none pending");
        end else begin
          logic [2*CW_W-1:0] e;
          e = exp_q.pop_front();
          chkw("rt_cw0", codeword0, e[2*CW_W-1 -: CW_W]);
          chkw("rt_cw1", codeword1, e[CW_W-1:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [0:CW_W-1] a0, a1, b0c, b1c;
    logic got;
    int guard;

    vecs[0].b0 = {32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
    vecs[0].b1 = {32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27};
    vecs[0].e0 = {32'h10, 32'h11, 32'h12, 32'h13, 32'h20, 32'h21, 32'h22, 32'h23};
    vecs[0].e1 = {32'h14, 32'h15, 32'h16, 32'h17, 32'h24, 32'h25, 32'h26, 32'h27};
    vecs[1].b0 = {32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000,
                  32'h5555_0000, 32'h6666_0000, 32'h7777_0000, 32'h8888_0000};
    vecs[1].b1 = {32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 32'h4444_0001,
                  32'h5555_0001, 32'h6666_0001, 32'h7777_0001, 32'h8888_0001};
    vecs[1].e0 = {32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000,
                  32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 32'h4444_0001};
    vecs[1].e1 = {32'h5555_0000, 32'h6666_0000, 32'h7777_0000, 32'h8888_0000,
                  32'h5555_0001, 32'h6666_0001, 32'h7777_0001, 32'h8888_0001};
    vecs[2].b0 = {8{32'hFFFF_FFFF}};
    vecs[2].b1 = {8{32'h0000_0000}};
    vecs[2].e0 = {{4{32'hFFFF_FFFF}}, {4{32'h0000_0000}}};
    vecs[2].e1 = {{4{32'hFFFF_FFFF}}, {4{32'h0000_0000}}};

    // Reset state
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, '0);
    repeat (3) tick();
    rst = 1'b0;
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_cw0", codeword0, '0);
    chkw("rst_cw1", codeword1, '0);
    chk1("rst_err", err_resync, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);

    // Table-driven single blocks
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, vecs[i].b0);
      chk1("tbl_ready_b0", in_ready, 1'b1);
      tick();
      chk1("tbl_valid_after_b0", out_valid, 1'b0);
      drive(1'b1, 1'b0, vecs[i].b1);
      tick();
      chk1("tbl_valid_after_b1", out_valid, 1'b1);
      chkw("tbl_cw0", codeword0, vecs[i].e0);
      chkw("tbl_cw1", codeword1, vecs[i].e1);
      drive(1'b0, 1'b0, '0);
      tick();
      chk1("tbl_consumed", out_valid, 1'b0);
    end

    // Back-to-back blocks, downstream always ready
    for (int k = 0; k < 3; k++) begin
      rand_cw(a0);
      rand_cw(a1);
      drive(1'b1, 1'b1, map_beat(a0, a1, 0));
      chk1("b2b_ready_b0", in_ready, 1'b1);
      tick();
      drive(1'b1, 1'b0, map_beat(a0, a1, 1));
      chk1("b2b_ready_b1", in_ready, 1'b1);
      tick();
      chk1("b2b_valid", out_valid, 1'b1);
      chkw("b2b_cw0", codeword0, a0);
      chkw("b2b_cw1", codeword1, a1);
    end
    drive(1'b0, 1'b0, '0);
    tick();

    // Stall: block A held, block B final beat waits until A is taken
    out_ready = 1'b0;
    rand_cw(a0);
    rand_cw(a1);
    rand_cw(b0c);
    rand_cw(b1c);
    drive(1'b1, 1'b1, map_beat(a0, a1, 0));
    tick();
    drive(1'b1, 1'b0, map_beat(a0, a1, 1));
    tick();
    chk1("stall_a_valid", out_valid, 1'b1);
    drive(1'b1, 1'b1, map_beat(b0c, b1c, 0));
    chk1("stall_b0_ready", in_ready, 1'b1);
    tick();
    chkw("stall_a_hold0", codeword0, a0);
    drive(1'b1, 1'b0, map_beat(b0c, b1c, 1));
    chk1("stall_b1_blocked", in_ready, 1'b0);
    tick();
    tick();
    chk1("stall_b1_still_blocked", in_ready, 1'b0);
    chk1("stall_a_valid_hold", out_valid, 1'b1);
    chkw("stall_a_hold0b", codeword0, a0);
    chkw("stall_a_hold1b", codeword1, a1);
    out_ready = 1'b1;
    #1;
    chk1("stall_release_ready", in_ready, 1'b1);
    tick();
    chk1("stall_b_valid", out_valid, 1'b1);
    chkw("stall_b_cw0", codeword0, b0c);
    chkw("stall_b_cw1", codeword1, b1c);
    drive(1'b0, 1'b0, '0);
    tick();
    chk1("stall_b_consumed", out_valid, 1'b0);

    // Resync: second in_first drops the partial block
    rand_cw(a0);
    rand_cw(a1);
    rand_cw(b0c);
    rand_cw(b1c);
    drive(1'b1, 1'b1, map_beat(a0, a1, 0));
    tick();
    chk1("resync_quiet", err_resync, 1'b0);
    drive(1'b1, 1'b1, map_beat(b0c, b1c, 0));
    tick();
    chk1("resync_pulse", err_resync, 1'b1);
    chk1("resync_no_output", out_valid, 1'b0);
    drive(1'b1, 1'b0, map_beat(b0c, b1c, 1));
    tick();
    chk1("resync_once", err_resync, 1'b0);
    chk1("resync_valid", out_valid, 1'b1);
    chkw("resync_cw0", codeword0, b0c);
    chkw("resync_cw1", codeword1, b1c);
    drive(1'b0, 1'b0, '0);
    tick();

    // Reset mid-block while a block is held
    out_ready = 1'b0;
    rand_cw(a0);
    rand_cw(a1);
    drive(1'b1, 1'b1, map_beat(a0, a1, 0));
    tick();
    drive(1'b1, 1'b0, map_beat(a0, a1, 1));
    tick();
    drive(1'b1, 1'b1, map_beat(a1, a0, 0));
    tick();
    drive(1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk1("rstmid_valid", out_valid, 1'b0);
    chkw("rstmid_cw0", codeword0, '0);
    chk1("rstmid_ready", in_ready, 1'b1);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    rand_cw(b0c);
    rand_cw(b1c);
    drive(1'b1, 1'b0, map_beat(b0c, b1c, 0));
    tick();
    chk1("rstmid_no_err", err_resync, 1'b0);
    chk1("rstmid_no_valid", out_valid, 1'b0);
    drive(1'b1, 1'b0, map_beat(b0c, b1c, 1));
    tick();
    chk1("rstmid_new_valid", out_valid, 1'b1);
    chkw("rstmid_cw0_new", codeword0, b0c);
    chkw("rstmid_cw1_new", codeword1, b1c);
    drive(1'b0, 1'b0, '0);
    tick();

    // Randomized round trip through the transmit-side model
    mon_en = 1'b1;
    for (int blk = 0; blk < 1000; blk++) begin
      rand_cw(a0);
      rand_cw(a1);
      exp_q.push_back({a0, a1});
      for (int b = 0; b < SYM_PER_LAYER; b++) begin
        repeat ($urandom_range(0, 2)) begin
          out_ready = ($urandom_range(0, 9) < 7);
          drive(1'b0, 1'b0, {8{$urandom()}});
          tick();
        end
        drive(1'b1, (b == 0), map_beat(a0, a1, b));
        guard = 0;
        got = 1'b0;
        while (!got && guard < 50) begin
          out_ready = ($urandom_range(0, 9) < 7);
          #1;
          got = in_ready;
          tick();
          guard++;
        end
        if (!got) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rt_beat_timeout: got no accept in 50 cycles, want accept");
        end
      end
      drive(1'b0, 1'b0, '0);
    end
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk1("rt_drained", (exp_q.size() == 0), 1'b1);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
